// File: rtl/esp_uart_tx_arb.sv
// esp_uart_tx_arb: message-granular round-robin arbiter sharing one UART transmitter
// between two byte streams, with CTS hold-off, line break and lock timeout.
module esp_uart_tx_arb #(
    parameter int TO_W         = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter bit CTS_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req0_brk,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       uart_cts,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_break,
    input  logic       tx_busy,
    output logic       owner,
    output logic       locked,
    output logic       lock_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_DRAIN, S_BREAK} state_t;
    state_t          state, state_nx;
    logic            cts_m, cts_s;
    logic            rr;
    logic [TO_W-1:0] cnt;
    logic            sel, brk_go, rdy, acc, acc_last, own_valid, expire;
    logic [7:0]      acc_data;

    always_ff @(posedge clk) begin
        cts_m <= uart_cts;
        cts_s <= cts_m;
    end

    // A lock pins the grant to the owner; otherwise a tie goes to the port that did not win last.
    always_comb begin
        sel        = locked ? owner : (req0_valid && req1_valid) ? ~rr : req1_valid;
        brk_go     = !locked && req0_brk;
        rdy        = state == S_IDLE && !tx_busy && !(CTS_EN && cts_s) && !brk_go;
        req0_ready = rdy && !sel;
        req1_ready = rdy && sel;
        acc        = sel ? req1_valid && req1_ready : req0_valid && req0_ready;
        acc_data   = sel ? req1_data : req0_data;
        acc_last   = sel ? req1_last : req0_last;
        own_valid  = owner ? req1_valid : req0_valid;
        expire     = state == S_IDLE && locked && !own_valid && cnt == TO_W'(LOCK_TIMEOUT - 1);
        tx_valid   = state == S_ISSUE;
        tx_break   = state == S_BREAK;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = brk_go ? S_BREAK : acc ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nx = S_GUARD;
            S_GUARD: state_nx = S_DRAIN;
            S_DRAIN: state_nx = tx_busy ? S_DRAIN : S_IDLE;
            S_BREAK: state_nx = req0_brk ? S_BREAK : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tx_data      <= '0;
            owner        <= 1'b0;
            rr           <= 1'b1;
            locked       <= 1'b0;
            cnt          <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            lock_timeout <= expire;
            if (acc) begin
                tx_data <= acc_data;
                owner   <= sel;
                rr      <= sel;
                locked  <= !acc_last;
                cnt     <= '0;
            end else if (expire) begin
                locked <= 1'b0;
                cnt    <= '0;
            end else if (!locked) begin
                cnt <= '0;
            end else if (state == S_IDLE && !own_valid) begin
                cnt <= cnt + TO_W'(1);
            end
        end
    end
endmodule
